// File: rtl/pmod_i2c_sched.sv
// Bring-up sequencer and I2C job arbiter for the eurorack-pmod codec: releases pdn,
// runs codec config, EEPROM ID read, then periodic jack-detect polls.
module pmod_i2c_sched #(
    parameter int STARTUP_CYCLES   = 61440,
    parameter int JACK_POLL_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES   = 65535,
    parameter int MAX_RETRY        = 3
) (
    input  logic       i_clk_12mhz,
    input  logic       i_rst_n,
    input  logic       i_cfg_restart,
    input  logic       i_op_ready,
    input  logic       i_op_done,
    input  logic       i_op_err,
    output logic       o_op_valid,
    output logic [1:0] o_op_sel,
    output logic       o_op_abort,
    output logic       o_pdn,
    output logic       o_sample_en,
    output logic       o_eeprom_valid,
    output logic       o_jack_strobe,
    output logic       o_fault,
    output logic [1:0] o_retry_cnt,
    output logic [2:0] o_dbg_state
);

    localparam int HW = $clog2(STARTUP_CYCLES);
    localparam int JW = $clog2(JACK_POLL_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(STARTUP_CYCLES - 1);
    localparam logic [JW-1:0] JCK_LAST  = JW'(JACK_POLL_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]    MAX_R     = 2'(MAX_RETRY);

    localparam logic [1:0] JOB_CFG = 2'd0;
    localparam logic [1:0] JOB_EEP = 2'd1;
    localparam logic [1:0] JOB_JCK = 2'd2;

    typedef enum logic [2:0] {
        ST_HOLD  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [HW-1:0] r_hold_cnt;
    logic [JW-1:0] r_jck_tmr;
    logic [TW-1:0] r_to_cnt;
    logic          r_cfg_pend;
    logic          r_eep_pend;
    logic          r_jck_pend;
    logic          r_rst_req;
    logic [1:0]    r_sel;
    logic          r_pdn;
    logic          r_sample_en;
    logic          r_eeprom_valid;
    logic          r_strobe;
    logic          r_abort;
    logic          r_fault;
    logic [1:0]    r_retry;

    logic          w_pick_ok;
    logic [1:0]    w_pick;
    logic          w_hold_last;
    logic          w_jck_wrap;
    logic          w_timeout;
    logic          w_ok;
    logic          w_fail;
    logic          w_exhaust;
    logic          w_restart_pend;

    assign w_hold_last    = (r_hold_cnt == HOLD_LAST);
    assign w_jck_wrap     = r_sample_en && (r_jck_tmr == JCK_LAST);
    // A done arriving on the timeout cycle wins over the timeout.
    assign w_timeout      = (r_state == ST_WAIT) && (r_to_cnt == TO_LAST) && !i_op_done;
    assign w_ok           = (r_state == ST_WAIT) && i_op_done && !i_op_err;
    assign w_fail         = (r_state == ST_WAIT) && ((i_op_done && i_op_err) || w_timeout);
    assign w_exhaust      = w_fail && (r_sel != JOB_JCK) && (r_retry >= MAX_R);
    assign w_restart_pend = i_cfg_restart || r_rst_req;

    always_ff @(posedge i_clk_12mhz or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_HOLD;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pick_ok   = 1'b0;
        w_pick      = JOB_CFG;
        if (r_cfg_pend) begin
            w_pick_ok = 1'b1;
            w_pick    = JOB_CFG;
        end else if (r_sample_en && r_eep_pend) begin
            w_pick_ok = 1'b1;
            w_pick    = JOB_EEP;
        end else if (r_sample_en && r_jck_pend) begin
            w_pick_ok = 1'b1;
            w_pick    = JOB_JCK;
        end
        case (r_state)
            ST_HOLD:  if (w_hold_last) w_state_nxt = ST_IDLE;
            // A restart in IDLE clears sample_en, so hold off one cycle to pick CFG.
            ST_IDLE:  if (w_pick_ok && !i_cfg_restart) w_state_nxt = ST_ISSUE;
            ST_ISSUE: if (i_op_ready) w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (w_ok || w_fail)
                    w_state_nxt = (w_exhaust && !w_restart_pend) ? ST_FAULT : ST_IDLE;
            end
            ST_FAULT: if (i_cfg_restart) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_HOLD;
        endcase
    end

    always_ff @(posedge i_clk_12mhz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hold_cnt     <= '0;
            r_jck_tmr      <= '0;
            r_to_cnt       <= '0;
            r_cfg_pend     <= 1'b0;
            r_eep_pend     <= 1'b0;
            r_jck_pend     <= 1'b0;
            r_rst_req      <= 1'b0;
            r_sel          <= JOB_CFG;
            r_pdn          <= 1'b0;
            r_sample_en    <= 1'b0;
            r_eeprom_valid <= 1'b0;
            r_strobe       <= 1'b0;
            r_abort        <= 1'b0;
            r_fault        <= 1'b0;
            r_retry        <= '0;
        end else begin
            r_strobe <= 1'b0;
            r_abort  <= 1'b0;
            if (r_state == ST_HOLD) begin
                if (w_hold_last) begin
                    r_pdn      <= 1'b1;
                    r_cfg_pend <= 1'b1;
                    r_eep_pend <= 1'b1;
                end else begin
                    r_hold_cnt <= r_hold_cnt + HW'(1);
                end
            end
            if (!r_sample_en || w_jck_wrap) r_jck_tmr <= '0;
            else                            r_jck_tmr <= r_jck_tmr + JW'(1);
            if (r_state == ST_IDLE && w_state_nxt == ST_ISSUE) r_sel <= w_pick;
            if (r_state == ST_ISSUE)     r_to_cnt <= '0;
            else if (r_state == ST_WAIT) r_to_cnt <= r_to_cnt + TW'(1);
            if (w_ok) begin
                r_retry <= '0;
                case (r_sel)
                    JOB_CFG: begin r_cfg_pend <= 1'b0; r_sample_en    <= 1'b1; end
                    JOB_EEP: begin r_eep_pend <= 1'b0; r_eeprom_valid <= 1'b1; end
                    default: begin r_jck_pend <= 1'b0; r_strobe       <= 1'b1; end
                endcase
            end
            if (w_fail) begin
                r_abort <= w_timeout;
                if (r_sel == JOB_JCK)   r_jck_pend <= 1'b0;
                else if (r_retry < MAX_R) r_retry  <= r_retry + 2'd1;
                else                    r_fault    <= 1'b1;
            end
            // A wrap while a poll is pending or in flight merges into it.
            if (w_jck_wrap) r_jck_pend <= 1'b1;
            if (i_cfg_restart && r_state != ST_HOLD) begin
                r_cfg_pend  <= 1'b1;
                r_sample_en <= 1'b0;
                r_jck_pend  <= 1'b0;
                if (r_state != ST_WAIT) begin
                    r_fault <= 1'b0;
                    r_retry <= '0;
                end else if (!w_ok && !w_fail) begin
                    r_rst_req <= 1'b1;
                end
            end
            // Restart is applied after the finishing op's own outcome.
            if ((w_ok || w_fail) && w_restart_pend) begin
                r_cfg_pend  <= 1'b1;
                r_sample_en <= 1'b0;
                r_jck_pend  <= 1'b0;
                r_fault     <= 1'b0;
                r_retry     <= '0;
                r_rst_req   <= 1'b0;
            end
        end
    end

    // Handshake: op_valid stays high with op_sel stable until the cycle op_ready is high;
    // that cycle is the accept, and op_valid drops on the next cycle.
    assign o_op_valid     = (r_state == ST_ISSUE);
    assign o_op_sel       = r_sel;
    assign o_op_abort     = r_abort;
    assign o_pdn          = r_pdn;
    assign o_sample_en    = r_sample_en;
    assign o_eeprom_valid = r_eeprom_valid;
    assign o_jack_strobe  = r_strobe;
    assign o_fault        = r_fault;
    assign o_retry_cnt    = r_retry;
    assign o_dbg_state    = r_state;

endmodule
